lif_spike_rate_monitor: RTL and testbench



---
 rtl/lif_spike_rate_monitor_pkg.sv | 21 ++
 rtl/lif_spike_rate_monitor_edge_detect.sv | 23 ++
 rtl/lif_spike_rate_monitor.sv | 155 +++++++++++++++
 tb/tb_lif_spike_rate_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_spike_rate_monitor_pkg.sv
// lif_mon_pkg: shared types and constants for the LIF spike-rate monitor.
//   mon_state_e : FSM state encoding (IDLE / MEASURE / HOLD)
//   *_W_DEF     : default widths for window length, spike count and ISI
//   CNT_MAX     : saturation value of the spike count at the default width
//   ISI_MAX     : saturation value of the ISI counter at the default width
package lif_mon_pkg;

  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
  localparam int ISI_W_DEF = 12;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};
  localparam logic [ISI_W_DEF-1:0] ISI_MAX = {ISI_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLD    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/lif_spike_rate_monitor_edge_detect.sv
// spike_edge_detect: one-cycle rising-edge pulse from a level input.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_spike      : level input, synchronous to i_clk
//   o_edge       : i_spike & ~previous sample, combinational in the current cycle
// The history register updates every cycle unconditionally, so a level held
// high for many cycles yields exactly one edge.
module spike_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_spike,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_spike;
  end

  assign o_edge = i_spike & ~r_prev;

endmodule

// File: rtl/lif_spike_rate_monitor.sv
// lif_spike_rate_monitor: per-window spike statistics of a LIF neuron output.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_spike_in       : neuron spike level
//   i_enable         : run measurement windows while high
//   i_window_len     : window length in cycles (0 treated as 1), latched at start
//   i_result_ready   : consumer accepts the held result
//   o_result_valid   : result fields valid and stable (FSM in HOLD)
//   o_spike_count    : rising edges in the window, saturating
//   o_isi_min        : minimum inter-edge interval, all-ones if fewer than 2 edges
//   o_overflow       : an edge arrived while the count was already saturated
//   o_busy           : FSM in MEASURE
//   o_state          : current FSM state, for debug/observation
// Handshake: a result transfers on any cycle where o_result_valid and
// i_result_ready are both high; o_result_valid then stays high and the fields
// stay frozen until that transfer happens.
module lif_spike_rate_monitor
  import lif_mon_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ISI_W = ISI_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_spike_in,
  input  logic             i_enable,
  input  logic [WIN_W-1:0] i_window_len,
  input  logic             i_result_ready,
  output logic             o_result_valid,
  output logic [CNT_W-1:0] o_spike_count,
  output logic [ISI_W-1:0] o_isi_min,
  output logic             o_overflow,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] L_ISI_MAX = {ISI_W{1'b1}};

  mon_state_e       r_state, w_state_nxt;
  logic             w_edge, w_start, w_last, w_commit;
  logic [WIN_W-1:0] r_win_left;
  logic [CNT_W-1:0] r_cnt, w_cnt_acc, r_cnt_out;
  logic             r_ovf, w_ovf_acc, r_ovf_out;
  logic             r_seen;
  logic [ISI_W-1:0] r_isi_run, r_isi_min, w_isi_min_acc, r_isi_out;

  spike_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_spike (i_spike_in),
    .o_edge  (w_edge)
  );

  assign w_last = (r_win_left == WIN_W'(1));

  // Accumulator values including the current cycle's edge; used both for the
  // running update and for the final-cycle commit, so a last-cycle edge counts.
  always_comb begin
    w_cnt_acc     = r_cnt;
    w_ovf_acc     = r_ovf;
    w_isi_min_acc = r_isi_min;
    if (w_edge) begin
      if (r_cnt == L_CNT_MAX) w_ovf_acc = 1'b1;
      else                    w_cnt_acc = r_cnt + CNT_W'(1);
      // r_isi_run already equals (now - previous edge), saturated
      if (r_seen && (r_isi_run < r_isi_min)) w_isi_min_acc = r_isi_run;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_start     = 1'b1;
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (!i_enable)   w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_result_ready) begin
          if (i_enable) begin
            w_start     = 1'b1;
            w_state_nxt = ST_MEASURE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_commit = (r_state == ST_MEASURE) && i_enable && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win_left <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_seen     <= 1'b0;
      r_isi_run  <= '0;
      r_isi_min  <= L_ISI_MAX;
    end else if (w_start) begin
      r_win_left <= (i_window_len == '0) ? WIN_W'(1) : i_window_len;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_seen     <= 1'b0;
      r_isi_run  <= '0;
      r_isi_min  <= L_ISI_MAX;
    end else if (r_state == ST_MEASURE) begin
      r_win_left <= r_win_left - WIN_W'(1);
      r_cnt      <= w_cnt_acc;
      r_ovf      <= w_ovf_acc;
      r_isi_min  <= w_isi_min_acc;
      if (w_edge) begin
        r_seen    <= 1'b1;
        r_isi_run <= ISI_W'(1);
      end else if (r_isi_run != L_ISI_MAX) begin
        r_isi_run <= r_isi_run + ISI_W'(1);
      end
    end
  end

  // Result fields only change on a completed window; aborts leave them alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_out <= '0;
      r_isi_out <= L_ISI_MAX;
      r_ovf_out <= 1'b0;
    end else if (w_commit) begin
      r_cnt_out <= w_cnt_acc;
      r_isi_out <= w_isi_min_acc;
      r_ovf_out <= w_ovf_acc;
    end
  end

  assign o_result_valid = (r_state == ST_HOLD);
  assign o_busy         = (r_state == ST_MEASURE);
  assign o_spike_count  = r_cnt_out;
  assign o_isi_min      = r_isi_out;
  assign o_overflow     = r_ovf_out;
  assign o_state        = r_state;

endmodule

// File: tb/tb_lif_spike_rate_monitor.sv
// Bench for lif_spike_rate_monitor. Inputs are driven and outputs sampled on
// the falling clock edge. Expected results come from a window model that
// scans the driven spike samples for rising edges and computes count, minimum
// interval and overflow with plain arithmetic.
module tb_lif_spike_rate_monitor;
  import lif_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_spike_in, i_enable, i_result_ready;
  logic [15:0] i_window_len;
  logic        o_result_valid, o_overflow, o_busy;
  logic [7:0]  o_spike_count;
  logic [11:0] o_isi_min;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  // expected result fields currently held by the DUT
  int exp_cnt = 0;
  int exp_isi = int'(ISI_MAX);
  int exp_ovf = 0;

  // spike samples for one window: entry 0 is the latch cycle, 1..L the window
  logic spk_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  lif_spike_rate_monitor dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_spike_in     (i_spike_in),
    .i_enable       (i_enable),
    .i_window_len   (i_window_len),
    .i_result_ready (i_result_ready),
    .o_result_valid (o_result_valid),
    .o_spike_count  (o_spike_count),
    .o_isi_min      (o_isi_min),
    .o_overflow     (o_overflow),
    .o_busy         (o_busy),
    .o_state        (o_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_count"}, 32'(o_spike_count), exp_cnt);
    check({tag, "_isi"},   32'(o_isi_min),     exp_isi);
    check({tag, "_ovf"},   32'(o_overflow),    exp_ovf);
  endtask

  // ---- stimulus generators ----
  task automatic fill_random(input int l_eff, input int pct);
    spk_q.delete();
    for (int k = 0; k <= l_eff; k++) spk_q.push_back($urandom_range(0, 99) < pct);
  endtask

  task automatic fill_const(input int l_eff);
    spk_q.delete();
    for (int k = 0; k <= l_eff; k++) spk_q.push_back(1'b0);
  endtask

  // ---- driver tasks ----
  // Start a window from IDLE (from_hold=0) or as the handshake of a held
  // result (from_hold=1). abort_at>0 drops enable in that window cycle.
  task automatic run_window(input int len, input bit from_hold, input int abort_at);
    int l_eff, n_edges, last, isi_m, d;
    l_eff   = (len == 0) ? 1 : len;
    n_edges = 0;
    last    = -1;
    isi_m   = int'(ISI_MAX);
    i_window_len   = 16'(len);
    i_enable       = 1'b1;
    i_result_ready = from_hold;
    i_spike_in     = spk_q[0];
    @(negedge clk);
    i_result_ready = 1'b0;
    for (int k = 1; k <= l_eff; k++) begin
      check("busy_in_window", 32'(o_busy), 1);
      check("valid_in_window", 32'(o_result_valid), 0);
      i_spike_in = spk_q[k];
      if (k == abort_at) begin
        i_enable = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_valid", 32'(o_result_valid), 0);
        check_fields("abort_hold");
        return;
      end
      if (spk_q[k] && !spk_q[k-1]) begin
        if (last >= 0) begin
          d = k - last;
          if (d > int'(ISI_MAX)) d = int'(ISI_MAX);
          if (d < isi_m) isi_m = d;
        end
        last = k;
        n_edges++;
      end
      @(negedge clk);
    end
    exp_cnt = (n_edges > 255) ? 255 : n_edges;
    exp_ovf = (n_edges > 255) ? 1 : 0;
    exp_isi = isi_m;
    check("result_valid", 32'(o_result_valid), 1);
    check("result_busy", 32'(o_busy), 0);
    check_fields("result");
  endtask

  task automatic handshake_to_idle();
    i_enable       = 1'b0;
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    check("hs_valid_drop", 32'(o_result_valid), 0);
    check("hs_busy", 32'(o_busy), 0);
    check_fields("hs_keep");
  endtask

  task automatic backpressure(input int cycles);
    i_result_ready = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      i_spike_in = 1'($urandom_range(0, 1));
      i_enable   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", 32'(o_result_valid), 1);
      check_fields("bp");
    end
  endtask

  initial begin
    bit in_hold;
    int len, l_eff, ab;

    rst            = 1'b1;
    i_spike_in     = 1'b0;
    i_enable       = 1'b0;
    i_result_ready = 1'b0;
    i_window_len   = '0;
    #1;
    check("rst_valid", 32'(o_result_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    check_fields("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ready outside HOLD does nothing
    i_result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_result_ready = 1'b0;
    check("idle_ready_valid", 32'(o_result_valid), 0);
    check("idle_ready_busy", 32'(o_busy), 0);

    // basic: pulses at window cycles 2, 5, 9 -> 3 edges, min ISI 3
    fill_const(10);
    spk_q[2] = 1'b1; spk_q[5] = 1'b1; spk_q[9] = 1'b1;
    run_window(10, 1'b0, 0);
    check("basic_count_const", 32'(o_spike_count), 3);
    check("basic_isi_const", 32'(o_isi_min), 3);
    handshake_to_idle();

    // held level: one burst of 4 cycles -> one edge
    fill_const(10);
    for (int k = 3; k <= 6; k++) spk_q[k] = 1'b1;
    run_window(10, 1'b0, 0);

    // backpressure, then back-to-back window from HOLD
    backpressure(20);
    fill_random(15, 40);
    run_window(15, 1'b1, 0);
    handshake_to_idle();

    // saturation: toggling input, rising edge every 2 cycles
    fill_const(1000);
    for (int k = 0; k <= 1000; k++) spk_q[k] = 1'(k % 2);
    run_window(1000, 1'b0, 0);
    check("sat_count_const", 32'(o_spike_count), 255);
    check("sat_ovf_const", 32'(o_overflow), 1);
    check("sat_isi_const", 32'(o_isi_min), 2);
    handshake_to_idle();

    // abort mid-window keeps previous result
    fill_random(20, 50);
    run_window(20, 1'b0, 8);

    // window_len=0 acts as 1; edge in that only cycle counts
    fill_const(1);
    spk_q[1] = 1'b1;
    run_window(0, 1'b0, 0);
    handshake_to_idle();

    // ISI saturation with the second edge in the final window cycle
    fill_const(4200);
    spk_q[1] = 1'b1; spk_q[4200] = 1'b1;
    run_window(4200, 1'b0, 0);
    handshake_to_idle();

    // reset mid-window clears everything without a clock edge
    fill_random(30, 50);
    run_window(30, 1'b0, 0);
    handshake_to_idle();
    i_enable = 1'b1; i_window_len = 16'd10; i_spike_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_spike_in = ~i_spike_in;
    end
    rst = 1'b1;
    #1;
    exp_cnt = 0; exp_isi = int'(ISI_MAX); exp_ovf = 0;
    check("midrst_valid", 32'(o_result_valid), 0);
    check("midrst_busy", 32'(o_busy), 0);
    check_fields("midrst");
    i_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized windows, mixing back-to-back, backpressure and aborts
    in_hold = 1'b0;
    for (int r = 0; r < 30; r++) begin
      len   = $urandom_range(0, 40);
      l_eff = (len == 0) ? 1 : len;
      ab    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, l_eff)) : 0;
      fill_random(l_eff, $urandom_range(10, 70));
      if (in_hold) begin
        if ($urandom_range(0, 1) == 1) backpressure($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 1) begin
          run_window(len, 1'b1, ab);
        end else begin
          handshake_to_idle();
          run_window(len, 1'b0, ab);
        end
      end else begin
        run_window(len, 1'b0, ab);
      end
      in_hold = (ab == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
